// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned RAM_AW = 10;
  localparam int unsigned RAM_DW = 32;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  typedef struct packed {
    logic                  req;
    logic [RAM_DW/8-1:0]   we;
    logic [RAM_AW-1:0]     addr;
    logic [RAM_DW-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the RAM port.
interface ram_arbiter_if #(
  parameter int unsigned AW = ram_arbiter_pkg::RAM_AW,
  parameter int unsigned DW = ram_arbiter_pkg::RAM_DW
);

  logic            m0_req;
  logic [DW/8-1:0] m0_we;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;

  logic            m1_req;
  logic [DW/8-1:0] m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;

  logic [AW-1:0]   ram_addr;
  logic [DW/8-1:0] ram_wea;
  logic [DW-1:0]   ram_dina;
  logic [DW-1:0]   ram_douta;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_douta,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_wea, ram_dina
  );

  // Requester / RAM-model side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_douta,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_wea, ram_dina
  );

endinterface

// File: rtl/ram_arb_rdtrack.sv
// Read-owner tag pipeline (RD_LAT deep) and read-data demux back to the owning master.
module ram_arb_rdtrack
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DW     = RAM_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  rd_tag_t       tag_i,
  input  logic [DW-1:0] ram_douta_i,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o
);

  rd_tag_t       tag_q [RD_LAT];
  rd_tag_t       tag_out;
  logic          ret0, ret1;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < int'(RD_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tag_out = tag_q[RD_LAT-1];
    ret0    = tag_out.valid & ~tag_out.id;
    ret1    = tag_out.valid & tag_out.id;
  end

  // rdata holds its last value between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ret0;
      rvalid1_q <= ret1;
      if (ret0) rdata0_q <= ram_douta_i;
      if (ret1) rdata1_q <= ram_douta_i;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter for the 1K x 32 data RAM; registered grants and RAM port.
// Optional RAM_ARB_STATS_EN adds saturating grant/conflict counters. AW/DW must match the package.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW     = RAM_AW,
  parameter int unsigned DW     = RAM_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  ram_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1,
  output logic [15:0] stat_conflict
`endif
);

  mem_req_t        m0, m1, sel;
  logic            last_q, last_d;
  logic            gnt0_d, gnt1_d, gnt0_q, gnt1_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW/8-1:0] wea_q, wea_d;
  logic [DW-1:0]   dina_q, dina_d;
  rd_tag_t         tag_d;

  always_comb begin
    m0.req   = bus.m0_req;
    m0.we    = bus.m0_we;
    m0.addr  = bus.m0_addr;
    m0.wdata = bus.m0_wdata;
    m1.req   = bus.m1_req;
    m1.we    = bus.m1_we;
    m1.addr  = bus.m1_addr;
    m1.wdata = bus.m1_wdata;
  end

  // On conflict the master other than last_q wins.
  always_comb begin
    gnt0_d = m0.req & (~m1.req | last_q);
    gnt1_d = m1.req & (~m0.req | ~last_q);
    sel    = gnt1_d ? m1 : m0;
    last_d = last_q;
    addr_d = addr_q;
    dina_d = dina_q;
    wea_d  = '0;
    tag_d  = '0;
    if (gnt0_d | gnt1_d) begin
      last_d      = gnt1_d;
      addr_d      = sel.addr;
      dina_d      = sel.wdata;
      wea_d       = sel.we;
      tag_d.valid = (sel.we == '0);
      tag_d.id    = gnt1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      addr_q <= '0;
      wea_q  <= '0;
      dina_q <= '0;
    end else begin
      last_q <= last_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      addr_q <= addr_d;
      wea_q  <= wea_d;
      dina_q <= dina_d;
    end
  end

  assign bus.m0_gnt   = gnt0_q;
  assign bus.m1_gnt   = gnt1_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_wea  = wea_q;
  assign bus.ram_dina = dina_q;

  logic          rv0, rv1;
  logic [DW-1:0] rd0, rd1;

  ram_arb_rdtrack #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdtrack (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_d),
    .ram_douta_i (bus.ram_douta),
    .m0_rvalid_o (rv0),
    .m0_rdata_o  (rd0),
    .m1_rvalid_o (rv1),
    .m1_rdata_o  (rd1)
  );

  assign bus.m0_rvalid = rv0;
  assign bus.m0_rdata  = rd0;
  assign bus.m1_rvalid = rv1;
  assign bus.m1_rdata  = rd1;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] sg0_q, sg1_q, sc_q;

  // Clear beats increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      sg0_q <= '0;
      sg1_q <= '0;
      sc_q  <= '0;
    end else begin
      if (gnt0_d && (sg0_q != 16'hFFFF)) sg0_q <= sg0_q + 16'd1;
      if (gnt1_d && (sg1_q != 16'hFFFF)) sg1_q <= sg1_q + 16'd1;
      if (m0.req && m1.req && (sc_q != 16'hFFFF)) sc_q <= sc_q + 16'd1;
    end
  end

  assign stat_gnt0     = sg0_q;
  assign stat_gnt1     = sg1_q;
  assign stat_conflict = sc_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, corner-case sequences, read-data scoreboard.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(RAM_AW), .DW(RAM_DW)) bus ();

`ifdef RAM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  ram_arbiter #(
    .AW     (RAM_AW),
    .DW     (RAM_DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict)
`endif
  );

  // RAM model clocked on the falling edge, byte-enabled writes.
  logic [31:0] ram_mem [1024];
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_wea[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_dina[8*b +: 8];
    bus.ram_douta <= ram_mem[bus.ram_addr];
  end

  typedef struct {
    logic        id;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + int'(RD_LAT);
    if (id) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic ret_check(input int id, input logic [31:0] d);
    exp_t e;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected m%0d_rvalid: got data %h, expected no return", id, d);
    end else begin
      if (id == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("m%0d rdata", id), d, e.data);
      chk($sformatf("m%0d rvalid cycle", id), cyc, e.cyc);
    end
  endtask

  // Scoreboard: every rvalid pops the owner's expected queue.
  always begin
    @(posedge clk);
    #1;
    if (bus.m0_rvalid) ret_check(0, bus.m0_rdata);
    if (bus.m1_rvalid) ret_check(1, bus.m1_rdata);
  end

  task automatic drive(input logic id, input logic req, input logic [3:0] we,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (id) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // Uncontended access: grant one cycle after the request edge, RAM port per vector.
  task automatic access(input vec_t v, input string tag);
    logic got;
    got = 1'b0;
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 4 && !got; k++) begin
      tick();
      if (v.id ? bus.m1_gnt : bus.m0_gnt) begin
        got = 1'b1;
        chk({tag, " latency"}, k, 1);
        chk({tag, " other gnt"}, v.id ? bus.m0_gnt : bus.m1_gnt, 0);
        chk({tag, " ram_addr"}, bus.ram_addr, v.addr);
        chk({tag, " ram_wea"}, bus.ram_wea, v.we);
        if (v.we != 4'b0) chk({tag, " ram_dina"}, bus.ram_dina, v.wdata);
        else push(v.id, v.exp_rdata);
      end
    end
    drive(v.id, 1'b0, 4'b0, 10'b0, 32'b0);
    chk({tag, " granted"}, got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " m0_gnt"}, bus.m0_gnt, 0);
    chk({tag, " m1_gnt"}, bus.m1_gnt, 0);
    chk({tag, " m0_rvalid"}, bus.m0_rvalid, 0);
    chk({tag, " m1_rvalid"}, bus.m1_rvalid, 0);
    chk({tag, " m0_rdata"}, bus.m0_rdata, 0);
    chk({tag, " m1_rdata"}, bus.m1_rdata, 0);
    chk({tag, " ram_addr"}, bus.ram_addr, 0);
    chk({tag, " ram_wea"}, bus.ram_wea, 0);
    chk({tag, " ram_dina"}, bus.ram_dina, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  int   exp_id, cnt0, cnt1;

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
    ram_mem[10'h005] = 32'hDEADBEEF;
    ram_mem[10'h010] = 32'h10101010;
    ram_mem[10'h020] = 32'h20202020;
    ram_mem[10'h3FF] = 32'hAABBCCDD;

    // Expected read data follows from the preload and the earlier writes in the table.
    vecs[0] = '{1'b1, 4'b0000, 10'h020, 32'h0,        32'h20202020};
    vecs[1] = '{1'b1, 4'b0011, 10'h3FF, 32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 4'b0000, 10'h3FF, 32'h0,        32'hAABB5678};
    vecs[3] = '{1'b0, 4'b1111, 10'h100, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 4'b0000, 10'h100, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b0, 4'b1000, 10'h005, 32'h11223344, 32'h0};
    vecs[6] = '{1'b1, 4'b0000, 10'h005, 32'h0,        32'h11ADBEEF};
    vecs[7] = '{1'b1, 4'b0100, 10'h020, 32'h00990000, 32'h0};
    vecs[8] = '{1'b0, 4'b0000, 10'h020, 32'h0,        32'h20992020};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    drive(1'b1, 1'b0, 4'b0, 10'b0, 32'b0);
`ifdef RAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single read, m1 side untouched.
    access('{1'b0, 4'b0000, 10'h005, 32'h0, 32'hDEADBEEF}, "single read");
    repeat (2) tick();
    chk("single read m0_rdata held", bus.m0_rdata, 32'hDEADBEEF);
    chk("single read m1_rdata", bus.m1_rdata, 0);

    // Conflict straight after reset: m0 first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'b0, 10'h010, 32'h0);
    drive(1'b1, 1'b1, 4'b0, 10'h020, 32'h0);
    tick();
    chk("conflict first m0_gnt", bus.m0_gnt, 1);
    chk("conflict first m1_gnt", bus.m1_gnt, 0);
    chk("conflict first ram_addr", bus.ram_addr, 10'h010);
    push(1'b0, 32'h10101010);
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    tick();
    chk("conflict second m1_gnt", bus.m1_gnt, 1);
    chk("conflict second m0_gnt", bus.m0_gnt, 0);
    chk("conflict second ram_addr", bus.ram_addr, 10'h020);
    push(1'b1, 32'h20202020);
    drive(1'b1, 1'b0, 4'b0, 10'b0, 32'b0);
    repeat (2) tick();

    for (int i = 0; i < 9; i++) access(vecs[i], $sformatf("vec%0d", i));
    repeat (2) tick();

    // Continuous conflict: the table ended on m0, so m1 leads.
    drive(1'b0, 1'b1, 4'b0, 10'h100, 32'h0);
    drive(1'b1, 1'b1, 4'b0, 10'h3FF, 32'h0);
    exp_id = 1;
    cnt0   = 0;
    cnt1   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("alternate %0d m0_gnt", i), bus.m0_gnt, (exp_id == 0) ? 1 : 0);
      chk($sformatf("alternate %0d m1_gnt", i), bus.m1_gnt, (exp_id == 1) ? 1 : 0);
      if (bus.m0_gnt) cnt0++;
      if (bus.m1_gnt) cnt1++;
      if (exp_id == 0) push(1'b0, 32'hCAFEF00D);
      else push(1'b1, 32'hAABB5678);
      exp_id = 1 - exp_id;
    end
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    drive(1'b1, 1'b0, 4'b0, 10'b0, 32'b0);
    chk("alternate m0 count", cnt0, 4);
    chk("alternate m1 count", cnt1, 4);
    repeat (2) tick();

    // Reset in the cycle after a read grant drops the read.
    drive(1'b0, 1'b1, 4'b0, 10'h005, 32'h0);
    tick();
    chk("midreset m0_gnt", bus.m0_gnt, 1);
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midreset");
    repeat (3) tick();
    drive(1'b0, 1'b1, 4'b0, 10'h100, 32'h0);
    drive(1'b1, 1'b1, 4'b0, 10'h3FF, 32'h0);
    tick();
    chk("post-reset conflict m0_gnt", bus.m0_gnt, 1);
    chk("post-reset conflict m1_gnt", bus.m1_gnt, 0);
    push(1'b0, 32'hCAFEF00D);
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    drive(1'b1, 1'b0, 4'b0, 10'b0, 32'b0);
    repeat (3) tick();

`ifdef RAM_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'b1111, 10'h200, 32'h0);
    drive(1'b1, 1'b1, 4'b1111, 10'h200, 32'h0);
    repeat (3) tick();
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    drive(1'b1, 1'b0, 4'b0, 10'b0, 32'b0);
    tick();
    chk("stat_conflict", stat_conflict, 3);
    chk("stat_gnt0", stat_gnt0, 2);
    chk("stat_gnt1", stat_gnt1, 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("cleared stat_conflict", stat_conflict, 0);
    chk("cleared stat_gnt0", stat_gnt0, 0);
    chk("cleared stat_gnt1", stat_gnt1, 0);
    drive(1'b0, 1'b1, 4'b1111, 10'h200, 32'h0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clear beats increment", stat_gnt0, 0);
    repeat (70000) tick();
    drive(1'b0, 1'b0, 4'b0, 10'b0, 32'b0);
    tick();
    chk("saturated stat_gnt0", stat_gnt0, 16'hFFFF);
    chk("saturation stat_conflict", stat_conflict, 0);
`endif

    repeat (3) tick();
    chk("m0 pending returns", q0.size(), 0);
    chk("m1 pending returns", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
